// File: rtl/quad_core_machine_pkg.sv
// Shared types, sizes and constant-matrix generators for the quad-core 4x4 matrix multiplier.
package quad_core_machine_pkg;

    localparam int unsigned N            = 4;
    localparam int unsigned DefaultDataW = 8;
    localparam int unsigned DefaultAccW  = 2 * DefaultDataW + 2;
    localparam int unsigned RunLast      = 18;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } state_e;

    // A[i][k] = 4i+k+1
    function automatic logic [4:0] a_elem(input logic [1:0] i, input logic [1:0] k);
        return {1'b0, i, k} + 5'd1;
    endfunction

    // B[k][j] = 16-(4k+j)
    function automatic logic [4:0] b_elem(input logic [1:0] k, input logic [1:0] j);
        return 5'd16 - {1'b0, k, j};
    endfunction

endpackage

// File: rtl/quad_core_machine_mac.sv
// One MAC core: walks n = 0..15 once t reaches CORE_ID and emits one C-row element every 4 MACs.
module mac_core
    import quad_core_machine_pkg::*;
#(
    parameter int unsigned CORE_ID = 0,
    parameter int unsigned DATA_W  = DefaultDataW,
    parameter int unsigned ACC_W   = 2 * DATA_W + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic [4:0]       t,
    output logic             wr_en,
    output logic [1:0]       wr_col,
    output logic [ACC_W-1:0] wr_data
);

    logic [4:0]          n_q, n_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                active;
    logic [1:0]          k;
    logic [DATA_W-1:0]   a_val, b_val;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    sum;

    assign k      = n_q[1:0];
    // n_q[4] marks the row as finished after the 16th MAC
    assign active = run && (t >= 5'(CORE_ID)) && !n_q[4];

    assign a_val = DATA_W'(a_elem(2'(CORE_ID), k));
    assign b_val = DATA_W'(b_elem(k, n_q[3:2]));
    assign prod  = (2 * DATA_W)'(a_val) * (2 * DATA_W)'(b_val);
    assign sum   = acc_q + ACC_W'(prod);

    assign wr_en   = active && (k == 2'd3);
    assign wr_col  = n_q[3:2];
    assign wr_data = sum;

    always_comb begin
        n_d   = n_q;
        acc_d = acc_q;
        if (clear) begin
            n_d   = '0;
            acc_d = '0;
        end else if (active) begin
            n_d   = n_q + 5'd1;
            acc_d = (k == 2'd3) ? '0 : sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q   <= '0;
            acc_q <= '0;
        end else begin
            n_q   <= n_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/quad_core_machine.sv
// Four-core 4x4 matrix-multiply engine: C = A x B over fixed constants, cores staggered by one cycle.
// Optional QCM_PERF_COUNTER_EN adds a cycle_count output counting RUN cycles.
module quad_core_machine
    import quad_core_machine_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned ACC_W  = 2 * DATA_W + 2
) (
    input  logic             fast_clock,
    input  logic             rst_n,
    input  logic             start_process,
    output logic             g1,
    output logic             g2,
    output logic             g3,
    output logic [1:0]       status,
`ifdef QCM_PERF_COUNTER_EN
    output logic [15:0]      cycle_count,
`endif
    input  logic [3:0]       rd_addr,
    output logic [ACC_W-1:0] rd_data
);

    state_e           state_q, state_d;
    logic [4:0]       t_q, t_d;
    logic [3:1]       go_q, go_d;
    logic [ACC_W-1:0] c_q [N][N];
    logic [ACC_W-1:0] c_d [N][N];
    logic             load, run;

    logic             wr_en   [N];
    logic [1:0]       wr_col  [N];
    logic [ACC_W-1:0] wr_data [N];

    assign load = (state_q == StLoad);
    assign run  = (state_q == StRun);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        go_d    = go_q;
        case (state_q)
            StIdle: if (start_process) state_d = StLoad;
            StLoad: begin
                state_d = StRun;
                t_d     = '0;
                go_d    = '0;
            end
            StRun: begin
                // Flag c rises together with t reaching c, i.e. when core c starts
                for (int c = 1; c < N; c++) begin
                    if (t_q == 5'(c - 1)) go_d[c] = 1'b1;
                end
                if (t_q == 5'(RunLast)) state_d = StDone;
                else                    t_d     = t_q + 5'd1;
            end
            StDone: begin
                if (!start_process) begin
                    state_d = StIdle;
                    go_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        c_d = c_q;
        if (load) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) c_d[i][j] = '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en[i]) c_d[i][wr_col[i]] = wr_data[i];
            end
        end
    end

    always_ff @(posedge fast_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            t_q     <= '0;
            go_q    <= '0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) c_q[i][j] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            go_q    <= go_d;
            c_q     <= c_d;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_core
        mac_core #(
            .CORE_ID (gi),
            .DATA_W  (DATA_W),
            .ACC_W   (ACC_W)
        ) u_core (
            .clk     (fast_clock),
            .rst_n   (rst_n),
            .clear   (load),
            .run     (run),
            .t       (t_q),
            .wr_en   (wr_en[gi]),
            .wr_col  (wr_col[gi]),
            .wr_data (wr_data[gi])
        );
    end

`ifdef QCM_PERF_COUNTER_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)     cnt_d = '0;
        else if (run) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge fast_clock or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cycle_count = cnt_q;
`endif

    assign status  = state_q;
    assign g1      = go_q[1];
    assign g2      = go_q[2];
    assign g3      = go_q[3];
    assign rd_data = c_q[rd_addr[3:2]][rd_addr[1:0]];

endmodule

// File: tb/tb_quad_core_machine.sv
// Self-checking bench for quad_core_machine: behavioural model compared every cycle plus directed literals.
module tb_quad_core_machine;

    localparam int unsigned AccW = 18;

    logic            fast_clock    = 1'b0;
    logic            rst_n         = 1'b0;
    logic            start_process = 1'b0;
    logic            g1, g2, g3;
    logic [1:0]      status;
    logic [3:0]      rd_addr       = 4'd0;
    logic [AccW-1:0] rd_data;
`ifdef QCM_PERF_COUNTER_EN
    logic [15:0]     cycle_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 fast_clock = ~fast_clock;

    quad_core_machine #(
        .DATA_W (8),
        .ACC_W  (AccW)
    ) dut (
        .fast_clock    (fast_clock),
        .rst_n         (rst_n),
        .start_process (start_process),
        .g1            (g1),
        .g2            (g2),
        .g3            (g3),
        .status        (status),
`ifdef QCM_PERF_COUNTER_EN
        .cycle_count   (cycle_count),
`endif
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference C straight from the matrix definitions
    function automatic int c_ref(input int i, input int j);
        int s = 0;
        for (int k = 0; k < 4; k++) s += (4 * i + k + 1) * (16 - (4 * k + j));
        return s;
    endfunction

    // Model: phase 0 idle, 1 load, 2 run (m_t = run cycle), 3 done; m_cv marks C elements written
    int m_phase = 0;
    int m_t     = 0;
    int m_cnt   = 0;
    bit m_cv [4][4];

    always @(posedge fast_clock or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_t     = 0;
            m_cnt   = 0;
            for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m_cv[i][j] = 1'b0;
        end else begin
            case (m_phase)
                0: if (start_process) m_phase = 1;
                1: begin
                    m_phase = 2;
                    m_t     = 0;
                    m_cnt   = 0;
                    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m_cv[i][j] = 1'b0;
                end
                2: begin
                    // core c finishes column j at MAC n = 4j+3, i.e. run cycle c+4j+3
                    for (int c = 0; c < 4; c++)
                        for (int j = 0; j < 4; j++)
                            if (c + 4 * j + 3 == m_t) m_cv[c][j] = 1'b1;
                    m_cnt++;
                    if (m_t == 18) m_phase = 3;
                    else           m_t++;
                end
                default: if (!start_process) m_phase = 0;
            endcase
        end
    end

    logic [2:0] exp_go;
    int         exp_rd;

    always @(negedge fast_clock) begin
        for (int c = 1; c < 4; c++) exp_go[c-1] = (m_phase == 2 && m_t >= c) || m_phase == 3;
        exp_rd = m_cv[rd_addr[3:2]][rd_addr[1:0]] ? c_ref(int'(rd_addr[3:2]), int'(rd_addr[1:0])) : 0;
        check("model_status", 32'(status), 32'(m_phase));
        check("model_go", 32'({g3, g2, g1}), 32'(exp_go));
        check("model_rd_data", 32'(rd_data), 32'(exp_rd));
`ifdef QCM_PERF_COUNTER_EN
        check("model_cycle_count", 32'(cycle_count), 32'(m_cnt));
`endif
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (status !== 2'd3 && n < 40) begin
            @(posedge fast_clock);
            #2;
            n++;
        end
        check(name, 32'(status), 32'd3);
    endtask

    int lit_addr [4] = '{0, 3, 12, 15};
    int lit_val  [4] = '{80, 50, 560, 386};

    initial begin
        start_process = 1'b1;
        repeat (2) @(posedge fast_clock);
        for (int a = 0; a < 16; a++) begin
            @(posedge fast_clock);
            #2;
            rd_addr = 4'(a);
            #1;
            check("reset_rd_data", 32'(rd_data), 32'd0);
        end
        check("reset_status", 32'(status), 32'd0);
        check("reset_go", 32'({g3, g2, g1}), 32'd0);

        @(posedge fast_clock);
        #2;
        start_process = 1'b0;
        rst_n         = 1'b1;
        repeat (8) @(posedge fast_clock);
        #2;
        start_process = 1'b1;

        // e counts edges from E0
        for (int e = 0; e <= 20; e++) begin
            @(posedge fast_clock);
            #2;
            check("seq_status", 32'(status), (e == 0) ? 32'd1 : ((e < 20) ? 32'd2 : 32'd3));
            check("seq_go", 32'({g3, g2, g1}), 32'({e >= 4, e >= 3, e >= 2}));
        end
        repeat (3) begin
            @(posedge fast_clock);
            #2;
            check("done_hold", 32'(status), 32'd3);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge fast_clock);
            #2;
            rd_addr = 4'(lit_addr[i]);
            #1;
            check("done_literal", 32'(rd_data), 32'(lit_val[i]));
        end
`ifdef QCM_PERF_COUNTER_EN
        check("done_cycle_count", 32'(cycle_count), 32'd19);
`endif

        start_process = 1'b0;
        @(posedge fast_clock);
        #2;
        rd_addr = 4'd0;
        #1;
        check("idle_status", 32'(status), 32'd0);
        check("idle_go", 32'({g3, g2, g1}), 32'd0);
        check("idle_persist", 32'(rd_data), 32'd80);

        // Reset during RUN cycle t=8
        @(posedge fast_clock);
        #2;
        start_process = 1'b1;
        repeat (10) @(posedge fast_clock);
        #2;
        rst_n         = 1'b0;
        start_process = 1'b0;
        #1;
        check("midrun_status", 32'(status), 32'd0);
        for (int a = 0; a < 16; a++) begin
            @(posedge fast_clock);
            #2;
            rd_addr = 4'(a);
            #1;
            check("midrun_rd_data", 32'(rd_data), 32'd0);
        end
        @(posedge fast_clock);
        #2;
        rst_n         = 1'b1;
        start_process = 1'b1;
        wait_done("rerun_done");
        rd_addr = 4'd0;
        #1;
        check("rerun_c00", 32'(rd_data), 32'd80);
`ifdef QCM_PERF_COUNTER_EN
        check("rerun_cycle_count", 32'(cycle_count), 32'd19);
`endif
        start_process = 1'b0;

        for (int cyc = 0; cyc < 500; cyc++) begin
            @(posedge fast_clock);
            #2;
            rd_addr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) start_process = ~start_process;
            if (!rst_n)                             rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0)  rst_n = 1'b0;
        end
        rst_n = 1'b1;
        repeat (2) @(posedge fast_clock);
        #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
